lsq_param: RTL and testbench

- Parametrised in-order load/store queue for the Tomasulo RISC-V core. Sits between dispatch/ROB and the memory controller.
- Captures operands from two CDB ports and its own load result. Issues memory ops strictly from the head.
- Broadcasts load results on its own CDB port.
- Stores reach memory only after ROB commit; a flush discards speculative entries.

---
 rtl/lsq_param.sv | 226 ++++++++++++++++++++++
 tb/tb_lsq_param.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsq_param.sv
// In-order load/store queue: captures operands from the CDBs, issues memory ops from the head,
// holds stores until ROB commit, and broadcasts load results on its own CDB port.
module lsq_param #(
  parameter int DEPTH = 16,
  parameter int ROB_W = 4,
  parameter int XLEN  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             disp_valid,
  input  logic             disp_store,
  input  logic [1:0]       disp_size,
  input  logic             disp_unsigned,
  input  logic [XLEN-1:0]  disp_imm,
  input  logic [XLEN-1:0]  disp_v1,
  input  logic [XLEN-1:0]  disp_v2,
  input  logic             disp_r1,
  input  logic             disp_r2,
  input  logic [ROB_W-1:0] disp_rob,
  output logic             full,
  input  logic             cdbA_valid,
  input  logic [ROB_W-1:0] cdbA_tag,
  input  logic [XLEN-1:0]  cdbA_val,
  input  logic             cdbB_valid,
  input  logic [ROB_W-1:0] cdbB_tag,
  input  logic [XLEN-1:0]  cdbB_val,
  input  logic             commit_valid,
  input  logic [ROB_W-1:0] commit_rob,
  input  logic             flush,
  output logic             mem_req,
  output logic             mem_we,
  output logic [XLEN-1:0]  mem_addr,
  output logic [XLEN-1:0]  mem_wdata,
  output logic [1:0]       mem_size,
  input  logic             mem_done,
  input  logic [XLEN-1:0]  mem_rdata,
  output logic             ld_valid,
  output logic [ROB_W-1:0] ld_rob,
  output logic [XLEN-1:0]  ld_val,
  output logic             fsm_state
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
  state_t state, state_nx;

  logic [DEPTH-1:0] e_valid, e_store, e_unsigned, e_r1, e_r2, e_commit;
  logic [1:0]       e_size [DEPTH];
  logic [XLEN-1:0]  e_imm  [DEPTH];
  logic [XLEN-1:0]  e_v1   [DEPTH];
  logic [XLEN-1:0]  e_v2   [DEPTH];
  logic [ROB_W-1:0] e_rob  [DEPTH];

  logic [PW-1:0]    head, tail, idx;
  logic [CW-1:0]    count, keep;
  logic [DEPTH-1:0] keep_mask;
  logic             run, discard, accept, issue, retire, head_committed;

  // A and B before the registered load result; A wins when both match.
  function automatic logic tag_hit(input logic [ROB_W-1:0] t);
    return (cdbA_valid && cdbA_tag == t) || (cdbB_valid && cdbB_tag == t) ||
           (ld_valid && ld_rob == t);
  endfunction

  function automatic logic [XLEN-1:0] tag_val(input logic [ROB_W-1:0] t);
    if (cdbA_valid && cdbA_tag == t) return cdbA_val;
    if (cdbB_valid && cdbB_tag == t) return cdbB_val;
    return ld_val;
  endfunction

  function automatic logic [XLEN-1:0] size_mask(input logic [XLEN-1:0] d, input logic [1:0] sz);
    case (sz)
      2'd0:    return {{(XLEN-8){1'b0}}, d[7:0]};
      2'd1:    return {{(XLEN-16){1'b0}}, d[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] d, input logic [1:0] sz,
                                                  input logic uns);
    case (sz)
      2'd0:    return {{(XLEN-8){d[7] & ~uns}}, d[7:0]};
      2'd1:    return {{(XLEN-16){d[15] & ~uns}}, d[15:0]};
      default: return d;
    endcase
  endfunction

  assign full      = (count == CW'(DEPTH));
  assign fsm_state = (state == BUSY);
  assign accept    = rdy && disp_valid && !full && !flush;
  // A commit aimed at the head this cycle is honoured immediately.
  assign head_committed = e_commit[head] || (commit_valid && e_rob[head] == commit_rob);
  assign issue  = rdy && !flush && state == IDLE && e_valid[head] && e_r1[head] && e_r2[head] &&
                  (!e_store[head] || head_committed);
  assign retire = rdy && state == BUSY && mem_done;

  // Entries surviving a flush: an in-flight head op plus the committed stores right behind it.
  always_comb begin
    keep      = '0;
    keep_mask = '0;
    run       = 1'b1;
    idx       = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (run && e_valid[idx] &&
          ((e_store[idx] && e_commit[idx]) || (i == 0 && state == BUSY))) begin
        keep           = keep + CW'(1);
        keep_mask[idx] = 1'b1;
      end else begin
        run = 1'b0;
      end
    end
  end

  always_comb begin
    state_nx = state;
    if (rdy) begin
      case (state)
        IDLE:    if (issue) state_nx = BUSY;
        BUSY:    if (mem_done) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e_valid  <= '0;
      e_r1     <= '0;
      e_r2     <= '0;
      e_commit <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else if (rdy) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (e_valid[i] && !e_r1[i] && tag_hit(e_v1[i][ROB_W-1:0])) begin
          e_v1[i] <= tag_val(e_v1[i][ROB_W-1:0]);
          e_r1[i] <= 1'b1;
        end
        if (e_valid[i] && !e_r2[i] && tag_hit(e_v2[i][ROB_W-1:0])) begin
          e_v2[i] <= tag_val(e_v2[i][ROB_W-1:0]);
          e_r2[i] <= 1'b1;
        end
        if (commit_valid && e_valid[i] && e_store[i] && e_rob[i] == commit_rob)
          e_commit[i] <= 1'b1;
        if (flush && !keep_mask[i])
          e_valid[i] <= 1'b0;
      end
      if (retire) e_valid[head] <= 1'b0;
      if (accept) begin
        e_valid[tail]    <= 1'b1;
        e_store[tail]    <= disp_store;
        e_size[tail]     <= disp_size;
        e_unsigned[tail] <= disp_unsigned;
        e_imm[tail]      <= disp_imm;
        e_rob[tail]      <= disp_rob;
        e_commit[tail]   <= 1'b0;
        if (!disp_r1 && tag_hit(disp_v1[ROB_W-1:0])) begin
          e_v1[tail] <= tag_val(disp_v1[ROB_W-1:0]);
          e_r1[tail] <= 1'b1;
        end else begin
          e_v1[tail] <= disp_v1;
          e_r1[tail] <= disp_r1;
        end
        if (!disp_r2 && tag_hit(disp_v2[ROB_W-1:0])) begin
          e_v2[tail] <= tag_val(disp_v2[ROB_W-1:0]);
          e_r2[tail] <= 1'b1;
        end else begin
          e_v2[tail] <= disp_v2;
          e_r2[tail] <= disp_r2;
        end
      end
      if (retire) head <= head + PW'(1);
      if (flush) begin
        tail  <= head + keep[PW-1:0];
        count <= keep - CW'(retire);
      end else begin
        if (accept) tail <= tail + PW'(1);
        count <= count + CW'(accept) - CW'(retire);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_size  <= '0;
      ld_valid  <= 1'b0;
      ld_rob    <= '0;
      ld_val    <= '0;
      discard   <= 1'b0;
    end else if (rdy) begin
      ld_valid <= 1'b0;
      if (issue) begin
        mem_req   <= 1'b1;
        mem_we    <= e_store[head];
        mem_addr  <= e_v1[head] + e_imm[head];
        mem_size  <= e_size[head];
        mem_wdata <= size_mask(e_v2[head], e_size[head]);
      end else if (retire) begin
        mem_req <= 1'b0;
        if (!e_store[head] && !discard && !flush) begin
          ld_valid <= 1'b1;
          ld_rob   <= e_rob[head];
          ld_val   <= load_extend(mem_rdata, e_size[head], e_unsigned[head]);
        end
      end
      // A flushed load still finishes its handshake but must not broadcast.
      if (retire)
        discard <= 1'b0;
      else if (flush && state == BUSY && !e_store[head])
        discard <= 1'b1;
    end
  end
endmodule

// File: tb/tb_lsq_param.sv
// Directed and randomized checks of lsq_param (DEPTH=4) against a queue-level reference model.
module tb_lsq_param;
  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        disp_valid, disp_store, disp_unsigned, disp_r1, disp_r2;
  logic [1:0]  disp_size;
  logic [31:0] disp_imm, disp_v1, disp_v2;
  logic [3:0]  disp_rob;
  logic        full;
  logic        cdbA_valid, cdbB_valid;
  logic [3:0]  cdbA_tag, cdbB_tag;
  logic [31:0] cdbA_val, cdbB_val;
  logic        commit_valid;
  logic [3:0]  commit_rob;
  logic        flush;
  logic        mem_req, mem_we, mem_done;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_size;
  logic        ld_valid;
  logic [3:0]  ld_rob;
  logic [31:0] ld_val;
  logic        fsm_state;

  typedef struct {
    logic        store;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  rob;
  } op_t;

  op_t         model_q[$];
  logic [31:0] exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;

  lsq_param #(.DEPTH(4), .ROB_W(4), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .disp_valid(disp_valid), .disp_store(disp_store), .disp_size(disp_size),
    .disp_unsigned(disp_unsigned), .disp_imm(disp_imm), .disp_v1(disp_v1), .disp_v2(disp_v2),
    .disp_r1(disp_r1), .disp_r2(disp_r2), .disp_rob(disp_rob), .full(full),
    .cdbA_valid(cdbA_valid), .cdbA_tag(cdbA_tag), .cdbA_val(cdbA_val),
    .cdbB_valid(cdbB_valid), .cdbB_tag(cdbB_tag), .cdbB_val(cdbB_val),
    .commit_valid(commit_valid), .commit_rob(commit_rob), .flush(flush),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_size(mem_size), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .ld_valid(ld_valid), .ld_rob(ld_rob), .ld_val(ld_val), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference rules: byte/half loads take the low bits, signed ones subtract 2^n when negative.
  function automatic logic [31:0] model_load(input logic [31:0] d, input logic [1:0] sz,
                                             input logic uns);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = d % 256;
      if (!uns && v >= 128) v = v - 256;
    end else if (sz == 2'd1) begin
      v = d % 65536;
      if (!uns && v >= 32768) v = v - 65536;
    end else begin
      v = d;
    end
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] d, input logic [1:0] sz);
    if (sz == 2'd0) return d % 256;
    if (sz == 2'd1) return d % 65536;
    return d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    disp_valid = 0; disp_store = 0; disp_size = 0; disp_unsigned = 0;
    disp_imm = 0; disp_v1 = 0; disp_v2 = 0; disp_r1 = 0; disp_r2 = 0; disp_rob = 0;
    cdbA_valid = 0; cdbA_tag = 0; cdbA_val = 0;
    cdbB_valid = 0; cdbB_tag = 0; cdbB_val = 0;
    commit_valid = 0; commit_rob = 0; flush = 0; mem_done = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    model_q.delete();
    exp_q.delete();
  endtask

  task automatic dispatch(input logic st, input logic [1:0] sz, input logic uns,
                          input logic [31:0] imm, input logic [31:0] v1, input logic [31:0] v2,
                          input logic r1, input logic r2, input logic [3:0] rob);
    disp_store = st; disp_size = sz; disp_unsigned = uns; disp_imm = imm;
    disp_v1 = v1; disp_v2 = v2; disp_r1 = r1; disp_r2 = r2; disp_rob = rob;
    disp_valid = 1'b1;
    step();
    disp_valid = 1'b0;
  endtask

  task automatic expect_op(input logic st, input logic [1:0] sz, input logic uns,
                           input logic [31:0] addr, input logic [31:0] data, input logic [3:0] rob);
    op_t op;
    op.store = st; op.size = sz; op.uns = uns; op.addr = addr; op.data = data; op.rob = rob;
    model_q.push_back(op);
  endtask

  task automatic commit(input logic [3:0] rob);
    commit_valid = 1'b1;
    commit_rob   = rob;
    step();
    commit_valid = 1'b0;
  endtask

  // Wait for the next request, check it against the model, complete it, check the load result.
  task automatic serve(input logic [31:0] rdata);
    op_t op;
    int  waited = 0;
    if (model_q.size() == 0) begin
      chk("model_queue_nonempty", 32'(model_q.size()), 32'd1);
      return;
    end
    op = model_q.pop_front();
    while (!mem_req && waited < 50) begin
      step();
      waited++;
    end
    chk("mem_req_wait", 32'(mem_req), 32'd1);
    chk("mem_addr", mem_addr, op.addr);
    chk("mem_we", 32'(mem_we), 32'(op.store));
    chk("mem_size", 32'(mem_size), 32'(op.size));
    if (op.store) chk("mem_wdata", mem_wdata, model_store(op.data, op.size));
    mem_done  = 1'b1;
    mem_rdata = rdata;
    step();
    mem_done = 1'b0;
    chk("mem_req_drop", 32'(mem_req), 32'd0);
    if (!op.store) begin
      exp_q.push_back(model_load(rdata, op.size, op.uns));
      chk("ld_valid", 32'(ld_valid), 32'd1);
      chk("ld_rob", 32'(ld_rob), 32'(op.rob));
      chk("ld_val", ld_val, exp_q.pop_front());
    end else begin
      chk("ld_valid_store", 32'(ld_valid), 32'd0);
    end
  endtask

  initial begin
    logic [3:0]  next_rob;
    logic [3:0]  st_robs[$];
    rdy = 1'b1;
    idle_inputs();
    do_reset();

    // Reset state
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ld_valid", 32'(ld_valid), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_fsm", 32'(fsm_state), 32'd0);

    // LW, LBU, LB, LH on sign-heavy data
    dispatch(0, 2'd2, 0, 32'd4, 32'h100, 32'd0, 1, 1, 4'd1);
    expect_op(0, 2'd2, 0, 32'h104, 32'd0, 4'd1);
    serve(32'hFFFFFF80);
    dispatch(0, 2'd0, 1, 32'd4, 32'h100, 32'd0, 1, 1, 4'd2);
    expect_op(0, 2'd0, 1, 32'h104, 32'd0, 4'd2);
    serve(32'hFFFFFF80);
    dispatch(0, 2'd0, 0, 32'd4, 32'h100, 32'd0, 1, 1, 4'd3);
    expect_op(0, 2'd0, 0, 32'h104, 32'd0, 4'd3);
    serve(32'hFFFFFF80);
    dispatch(0, 2'd1, 0, 32'd0, 32'h120, 32'd0, 1, 1, 4'd4);
    expect_op(0, 2'd1, 0, 32'h120, 32'd0, 4'd4);
    serve(32'h12348001);

    // Store waits for commit, then issues on the following edge
    dispatch(1, 2'd2, 0, 32'd0, 32'h200, 32'hDEADBEEF, 1, 1, 4'd3);
    expect_op(1, 2'd2, 0, 32'h200, 32'hDEADBEEF, 4'd3);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("store_gated", 32'(mem_req), 32'd0);
    end
    commit(4'd3);
    chk("store_req_after_commit", 32'(mem_req), 32'd1);
    serve(32'd0);

    // Same-cycle capture from cdbB at dispatch
    cdbB_valid = 1'b1; cdbB_tag = 4'd5; cdbB_val = 32'h40;
    dispatch(0, 2'd2, 0, 32'h8, 32'd5, 32'd0, 0, 1, 4'd6);
    cdbB_valid = 1'b0;
    expect_op(0, 2'd2, 0, 32'h48, 32'd0, 4'd6);
    step();
    chk("wakeup_no_wait", 32'(mem_req), 32'd1);
    serve(32'h0BADF00D);

    // Later wakeup via cdbA snoop
    dispatch(0, 2'd2, 0, 32'h10, 32'd7, 32'd0, 0, 1, 4'd8);
    step();
    step();
    chk("snoop_waiting", 32'(mem_req), 32'd0);
    cdbA_valid = 1'b1; cdbA_tag = 4'd7; cdbA_val = 32'h300;
    step();
    cdbA_valid = 1'b0;
    expect_op(0, 2'd2, 0, 32'h310, 32'd0, 4'd8);
    serve(32'h55AA55AA);

    // rdy low drops a dispatch and freezes everything
    rdy = 1'b0;
    dispatch(0, 2'd2, 0, 32'd0, 32'h900, 32'd0, 1, 1, 4'd9);
    step();
    chk("rdy_low_no_req", 32'(mem_req), 32'd0);
    rdy = 1'b1;
    step();
    step();
    chk("rdy_low_not_queued", 32'(mem_req), 32'd0);

    // Randomized bursts of ready loads/stores
    next_rob = 4'd0;
    for (int it = 0; it < 10; it++) begin
      int unsigned nb;
      nb = $urandom_range(1, 3);
      st_robs.delete();
      for (int k = 0; k < int'(nb); k++) begin
        logic        st, uns;
        logic [1:0]  sz;
        logic [31:0] base, imm, data;
        st   = 1'($urandom_range(0, 1));
        uns  = 1'($urandom_range(0, 1));
        sz   = 2'($urandom_range(0, 2));
        base = $urandom;
        imm  = $urandom;
        data = $urandom;
        dispatch(st, sz, uns, imm, base, data, 1, 1, next_rob);
        expect_op(st, sz, uns, base + imm, data, next_rob);
        if (st) st_robs.push_back(next_rob);
        next_rob = next_rob + 4'd1;
      end
      foreach (st_robs[j]) commit(st_robs[j]);
      for (int k = 0; k < int'(nb); k++) serve($urandom);
    end

    // Full and wrap with DEPTH=4
    do_reset();
    dispatch(0, 2'd2, 0, 32'd0, 32'h10, 32'd0, 1, 1, 4'd1);
    expect_op(0, 2'd2, 0, 32'h10, 32'd0, 4'd1);
    chk("fill1_full", 32'(full), 32'd0);
    dispatch(0, 2'd2, 0, 32'h4, 32'd9, 32'd0, 0, 1, 4'd2);
    dispatch(0, 2'd2, 0, 32'h4, 32'd10, 32'd0, 0, 1, 4'd3);
    chk("fill3_full", 32'(full), 32'd0);
    dispatch(0, 2'd2, 0, 32'h4, 32'd11, 32'd0, 0, 1, 4'd4);
    chk("fill4_full", 32'(full), 32'd1);
    dispatch(0, 2'd2, 0, 32'd0, 32'h999, 32'd0, 1, 1, 4'd5);
    chk("reject5_full", 32'(full), 32'd1);
    serve(32'h11111111);
    chk("after_retire_full", 32'(full), 32'd0);
    dispatch(0, 2'd2, 0, 32'd0, 32'h60, 32'd0, 1, 1, 4'd6);
    chk("wrap_refill_full", 32'(full), 32'd1);
    cdbA_valid = 1'b1; cdbA_tag = 4'd9; cdbA_val = 32'h20;
    step();
    cdbA_tag = 4'd10; cdbA_val = 32'h30;
    step();
    cdbA_valid = 1'b0;
    cdbB_valid = 1'b1; cdbB_tag = 4'd11; cdbB_val = 32'h40;
    step();
    cdbB_valid = 1'b0;
    expect_op(0, 2'd2, 0, 32'h24, 32'd0, 4'd2);
    expect_op(0, 2'd2, 0, 32'h34, 32'd0, 4'd3);
    expect_op(0, 2'd2, 0, 32'h44, 32'd0, 4'd4);
    expect_op(0, 2'd2, 0, 32'h60, 32'd0, 4'd6);
    for (int k = 0; k < 4; k++) serve($urandom);
    step();
    step();
    chk("drained_req", 32'(mem_req), 32'd0);
    chk("drained_full", 32'(full), 32'd0);

    // Flush: busy LW at head, committed SB behind it, two younger loads
    do_reset();
    dispatch(0, 2'd2, 0, 32'd0, 32'h500, 32'd0, 1, 1, 4'd1);
    dispatch(1, 2'd0, 0, 32'd1, 32'h600, 32'hCAFE12AB, 1, 1, 4'd2);
    commit(4'd2);
    dispatch(0, 2'd2, 0, 32'd0, 32'h700, 32'd0, 1, 1, 4'd3);
    dispatch(0, 2'd2, 0, 32'd0, 32'h710, 32'd0, 1, 1, 4'd4);
    chk("flush_pre_full", 32'(full), 32'd1);
    chk("flush_pre_req", 32'(mem_req), 32'd1);
    chk("flush_pre_addr", mem_addr, 32'h500);
    flush = 1'b1;
    disp_store = 0; disp_size = 2'd2; disp_v1 = 32'h720; disp_imm = 0;
    disp_r1 = 1; disp_r2 = 1; disp_rob = 4'd5; disp_valid = 1'b1;
    step();
    flush = 1'b0;
    disp_valid = 1'b0;
    chk("flush_full", 32'(full), 32'd0);
    chk("flush_req_held", 32'(mem_req), 32'd1);
    expect_op(1, 2'd0, 0, 32'h601, 32'hCAFE12AB, 4'd2);
    dispatch(0, 2'd2, 0, 32'h8, 32'd12, 32'd0, 0, 1, 4'd6);
    chk("flush_count3_full", 32'(full), 32'd0);
    dispatch(0, 2'd2, 0, 32'hC, 32'd12, 32'd0, 0, 1, 4'd7);
    chk("flush_count4_full", 32'(full), 32'd1);
    mem_done  = 1'b1;
    mem_rdata = 32'h12345678;
    step();
    mem_done = 1'b0;
    chk("flush_ld_suppressed", 32'(ld_valid), 32'd0);
    chk("flush_lw_req_drop", 32'(mem_req), 32'd0);
    chk("flush_lw_retired_full", 32'(full), 32'd0);
    serve(32'd0);
    cdbA_valid = 1'b1; cdbA_tag = 4'd12; cdbA_val = 32'h800;
    step();
    cdbA_valid = 1'b0;
    expect_op(0, 2'd2, 0, 32'h808, 32'd0, 4'd6);
    expect_op(0, 2'd2, 0, 32'h80C, 32'd0, 4'd7);
    serve(32'hA5A5A5A5);
    serve(32'h5A5A5A5A);
    step();
    step();
    chk("flush_drained_req", 32'(mem_req), 32'd0);

    // Reset while BUSY
    do_reset();
    dispatch(0, 2'd2, 0, 32'd0, 32'h880, 32'd0, 1, 1, 4'd1);
    step();
    chk("busy_before_rst", 32'(fsm_state), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_q.delete();
    chk("rst_busy_mem_req", 32'(mem_req), 32'd0);
    chk("rst_busy_full", 32'(full), 32'd0);
    chk("rst_busy_ld_valid", 32'(ld_valid), 32'd0);
    chk("rst_busy_fsm", 32'(fsm_state), 32'd0);
    dispatch(0, 2'd1, 1, 32'd2, 32'h900, 32'd0, 1, 1, 4'd9);
    expect_op(0, 2'd1, 1, 32'h902, 32'd0, 4'd9);
    serve(32'hFFFF8765);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
